// File: rtl/ntt_bu_scheduler_if.sv
// Scheduler-to-datapath bundle: start/status plus coefficient read, twiddle and write-back strobes.
// The scheduler drives everything except start.
interface ntt_bu_scheduler_if #(
    parameter int LOGN = 4
);
    logic            start;
    logic            busy;
    logic            done;
    logic [LOGN-1:0] stage;
    logic            rd_en;
    logic [LOGN-1:0] rd_addr_a;
    logic [LOGN-1:0] rd_addr_b;
    logic [LOGN-1:0] tw_addr;
    logic            wr_en;
    logic [LOGN-1:0] wr_addr_a;
    logic [LOGN-1:0] wr_addr_b;

    modport master (
        input  start,
        output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        output start,
        input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/ntt_bu_scheduler.sv
// Issues one Cooley-Tukey butterfly per cycle for an in-place negacyclic NTT and
// replays each read address pair as a write-back pair PIPE_LAT cycles later.
module ntt_bu_scheduler #(
    parameter int LOGN   = 4,
    parameter int RD_LAT = 1,
    parameter int BU_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    ntt_bu_scheduler_if.master  bus
);
    localparam int PIPE_LAT = RD_LAT + BU_LAT;
    localparam int DW       = $clog2(PIPE_LAT + 1);
    localparam logic [LOGN-2:0] K_LAST = '1;
    localparam logic [DW-1:0]   D_LAST = DW'(PIPE_LAT - 1);
    localparam logic [LOGN-1:0] S_LAST = LOGN'(LOGN - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state;
    logic [LOGN-1:0] stage_q;
    logic [LOGN-2:0] k;
    logic [DW-1:0]   dcnt;
    logic            busy_q;
    logic            done_q;
    logic            rd_en_q;
    logic [LOGN-1:0] ra_q;
    logic [LOGN-1:0] rb_q;
    logic [LOGN-1:0] tw_q;

    logic            vld_p [PIPE_LAT];
    logic [LOGN-1:0] a_p   [PIPE_LAT];
    logic [LOGN-1:0] b_p   [PIPE_LAT];

    // Returns {addr_a, addr_b, tw_addr} for butterfly kk of stage s.
    function automatic logic [3*LOGN-1:0] bfly(input int unsigned s, input int unsigned kk);
        int unsigned half;
        int unsigned g;
        int unsigned j;
        int unsigned base;
        half = (1 << LOGN) >> (s + 1);
        g    = kk >> (LOGN - 1 - s);
        j    = kk & (half - 1);
        base = 2 * g * half;
        return {LOGN'(base + j), LOGN'(base + j + half), LOGN'((1 << s) + g)};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            stage_q <= '0;
            k       <= '0;
            dcnt    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            ra_q    <= '0;
            rb_q    <= '0;
            tw_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state              <= RUN;
                        stage_q            <= '0;
                        k                  <= '0;
                        busy_q             <= 1'b1;
                        rd_en_q            <= 1'b1;
                        {ra_q, rb_q, tw_q} <= bfly(0, 0);
                    end
                end
                RUN: begin
                    if (k == K_LAST) begin
                        state   <= DRAIN;
                        dcnt    <= '0;
                        rd_en_q <= 1'b0;
                    end else begin
                        k                  <= k + 1'b1;
                        {ra_q, rb_q, tw_q} <= bfly(32'(stage_q), 32'(k) + 1);
                    end
                end
                // Hold off the next stage until its last write-back has been issued.
                DRAIN: begin
                    if (dcnt == D_LAST) begin
                        if (stage_q == S_LAST) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state              <= RUN;
                            stage_q            <= stage_q + 1'b1;
                            k                  <= '0;
                            rd_en_q            <= 1'b1;
                            {ra_q, rb_q, tw_q} <= bfly(32'(stage_q) + 1, 0);
                        end
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    stage_q <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write-back delay line: reset clears it so in-flight butterflies never write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                vld_p[i] <= 1'b0;
                a_p[i]   <= '0;
                b_p[i]   <= '0;
            end
        end else begin
            vld_p[0] <= rd_en_q;
            a_p[0]   <= ra_q;
            b_p[0]   <= rb_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
                a_p[i]   <= a_p[i-1];
                b_p[i]   <= b_p[i-1];
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.stage     = stage_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr_a = ra_q;
    assign bus.rd_addr_b = rb_q;
    assign bus.tw_addr   = tw_q;
    assign bus.wr_en     = vld_p[PIPE_LAT-1];
    assign bus.wr_addr_a = a_p[PIPE_LAT-1];
    assign bus.wr_addr_b = b_p[PIPE_LAT-1];
endmodule
